mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Responder end of the core data-memory request interface. Accepts mem_read_req / mem_write_req
//  from the pipeline's memory stage and services one request at a time against a word-organised
//  on-chip RAM with programmable wait states. Returns read data or a write acknowledge with a 1-cycle
//  resp_valid pulse. Used as the data-side memory model/backing store in simulation and on FPGA.
// PARAMETERS
//  ADDR_W   10  log2 of RAM depth in words; RAM index = addr[ADDR_W+1:2], upper addr bits ignored (wrap)
//  LATENCY  2   wait-state cycles between accept and response, 0..15
//  INIT     0   word value every RAM location holds after reset
// PORTS
//  clk         in   1    clock, all state on rising edge
//  reset       in   1    asynchronous, active-high reset
//  rreq        in   mem_read_req   read request {valid, addr, size}
//  wreq        in   mem_write_req  write request {valid, addr, data, size, strobe}
//  req_ready   out  1    request accepted this cycle when (rreq.valid|wreq.valid) && req_ready
//  resp        out  mem_resp_t     {valid, is_write, err, data}
// BEHAVIOUR
//  - Reset (async): state=IDLE, req_ready=1, resp=0, wait counter=0. The RAM contents are not
//    reset; they initialise to INIT at time 0 only.
//  - FSM IDLE->WAIT->RESP->IDLE. IDLE: req_ready=1; on accept, capture the request and load cnt=LATENCY.
//    Go to WAIT if LATENCY>0, else go straight to RESP.
//  - WAIT: req_ready=0, cnt decrements each cycle; at cnt==1 go to RESP.
//  - Response latency: accept in cycle N gives resp.valid in cycle N+1+LATENCY, high for exactly 1 cycle.
//  - RESP: resp.valid=1, req_ready=0. Write: RAM bytes with strobe[i]=1 take data[8i+7:8i] at this edge,
//    and resp.data=0. Read: resp.data = whole RAM word, byte/half extraction is done by the initiator.
//    Next state is IDLE, which gives at least 1 idle cycle between responses.
//  - Simultaneous rreq.valid & wreq.valid in IDLE: the write is accepted; the read is not accepted and must
//    be held by the initiator. A read after a write to the same word returns the new data.
//  - Requests outside IDLE are ignored and are not queued; the initiator holds valid until it sees req_ready.
//  - strobe==0 on a write: no RAM change, normal ack. size is used only for the error check.
//  - Index wrap: an addr beyond 4*2^ADDR_W aliases modulo the depth; this is not an error.
//  - Reset mid-operation: the pending request is dropped, no RAM write, no response, FSM returns to IDLE.
// CONFIGURATION
//  MEM_RESP_ALIGN_CHECK_EN defined:
//   - Misaligned requests are flagged: size==1 && addr[0], or size==2 && addr[1:0]!=0.
//   - A misaligned request is still accepted and timed normally, but responds err=1, data=0, no RAM write.
//  Macro undefined: resp.err is tied to 0; addr[1:0] is ignored; writes follow strobe only.
// STRUCTURE
//  - common package additions:
//    - typedef struct packed {logic valid; logic is_write; logic err; word_t data;} mem_resp_t;
//    - typedef enum logic[1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_resp_state_t;
//  - One sub-module: mem_resp_ram.
//    - Ports: 2^ADDR_W x 32 synchronous RAM, byte write enables, async read of the captured index.
//    - Keeps the memory array separate from the FSM/handshake logic in this file.
// TESTING
//  - LATENCY=2, reset then write addr 0x10 data 0xDEADBEEF strobe 4'hF accepted cycle 5
//    -> resp.valid=1 is_write=1 in cycle 8 only.
//  - Then read 0x10 -> resp.data=0xDEADBEEF; req_ready low cycles accept+1..accept+3.
//  - Write 0x10 data 0x000000AA strobe 4'h1, read 0x10 -> 0xDEADBEAA.
//  - rreq(0x20) and wreq(0x20, 0x12345678, 4'hF) both valid with read held
//    -> write acked first, read then returns 0x12345678.
//  - LATENCY=0 -> resp.valid exactly 1 cycle after accept.
//  - ADDR_W=10: write 0x1004 then read 0x0004 -> same data (wrap).
//  - Assert reset during WAIT of a write to 0x30 -> no resp pulse, later read 0x30 returns INIT.
//  - MEM_RESP_ALIGN_CHECK_EN: write size=2 addr 0x42 -> err=1, data=0, word 0x40 unchanged.
//    Without the macro: err=0 and the strobed bytes are written.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the data-memory responder: request/response structs, FSM states, alignment helper.
// Request structs mirror what the pipeline memory stage drives; mem_resp_t is the registered reply.
package mem_responder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam int unsigned MR_CNT_W = 4;

    typedef struct packed {
        logic       valid;
        addr_t      addr;
        logic [1:0] size;
    } mem_read_req;

    typedef struct packed {
        logic       valid;
        addr_t      addr;
        word_t      data;
        logic [1:0] size;
        logic [3:0] strobe;
    } mem_write_req;

    typedef struct packed {
        logic  valid;
        logic  is_write;
        logic  err;
        word_t data;
    } mem_resp_t;

    typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_resp_state_t;

    // size encodes bytes as 0=byte, 1=half, 2=word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return ((size == 2'd1) && lsb[0]) || ((size == 2'd2) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory stage (master) and the responder (slave).
// The master holds a request valid until it observes req_ready high in the same cycle.
interface mem_responder_if;
    import mem_responder_pkg::*;

    mem_read_req  rreq;
    mem_write_req wreq;
    logic         req_ready;
    mem_resp_t    resp;

    modport master (output rreq, output wreq, input req_ready, input resp);
    modport slave  (input rreq, input wreq, output req_ready, output resp);

endinterface

// File: rtl/mem_resp_ram.sv
// Word-organised backing RAM: byte-enabled synchronous write, asynchronous read, no reset on contents.
// Contents start at INIT at time zero only; a reset of the responder leaves them untouched.
module mem_resp_ram
    import mem_responder_pkg::*;
#(
    parameter int    ADDR_W = 10,
    parameter word_t INIT   = '0
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  word_t             wdata_i,
    input  logic [3:0]        strobe_i,
    output word_t             rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    word_t mem_q [DEPTH] = '{default: INIT};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && strobe_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding data-memory responder: response LATENCY+1 cycles after accept, ready low until IDLE.
// Optional MEM_RESP_ALIGN_CHECK_EN flags misaligned half/word requests with err and suppresses the write.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    ADDR_W  = 10,
    parameter int    LATENCY = 2,
    parameter word_t INIT    = '0
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam logic [MR_CNT_W-1:0] CNT_INIT = MR_CNT_W'(LATENCY);

    mem_resp_state_t       state_q;
    logic [MR_CNT_W-1:0]   cnt_q;
    logic                  ready_q;
    mem_resp_t             resp_q;
    logic                  wr_q;
    logic                  err_q;
    logic [ADDR_W-1:0]     idx_q;
    word_t                 wdata_q;
    logic [3:0]            strobe_q;

    logic                  accept_d;
    logic                  wr_sel_d;
    addr_t                 addr_d;
    logic [1:0]            size_d;
    logic                  err_d;
    logic [ADDR_W-1:0]     idx_d;
    mem_resp_t             resp_d;

    logic [ADDR_W-1:0]     ram_idx;
    logic                  ram_we;
    word_t                 ram_rdata;
    logic                  unused_bits;

    // A pending write wins over a simultaneous read; the read stays held by the initiator.
    assign wr_sel_d = bus.wreq.valid;
    assign accept_d = (state_q == MR_IDLE) && (bus.rreq.valid || bus.wreq.valid);
    assign addr_d   = wr_sel_d ? bus.wreq.addr : bus.rreq.addr;
    assign size_d   = wr_sel_d ? bus.wreq.size : bus.rreq.size;
    assign idx_d    = addr_d[ADDR_W+1:2];

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign err_d = is_misaligned(size_d, addr_d[1:0]);
`else
    assign err_d = 1'b0;
`endif

    assign unused_bits = ^{addr_d[31:ADDR_W+2], addr_d[1:0], size_d};

    // In IDLE the RAM looks at the incoming index so a zero-latency read can respond next cycle.
    assign ram_idx = (state_q == MR_IDLE) ? idx_d : idx_q;
    assign ram_we  = (state_q == MR_RESP) && wr_q && !err_q;

    mem_resp_ram #(
        .ADDR_W (ADDR_W),
        .INIT   (INIT)
    ) u_ram (
        .clk      (clk),
        .we_i     (ram_we),
        .idx_i    (ram_idx),
        .wdata_i  (wdata_q),
        .strobe_i (strobe_q),
        .rdata_o  (ram_rdata)
    );

    always_comb begin
        resp_d          = '0;
        resp_d.valid    = 1'b1;
        resp_d.is_write = (state_q == MR_IDLE) ? wr_sel_d : wr_q;
        resp_d.err      = (state_q == MR_IDLE) ? err_d : err_q;
        resp_d.data     = (resp_d.is_write || resp_d.err) ? '0 : ram_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MR_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            resp_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
        end else begin
            case (state_q)
                MR_IDLE: begin
                    if (accept_d) begin
                        wr_q     <= wr_sel_d;
                        err_q    <= err_d;
                        idx_q    <= idx_d;
                        wdata_q  <= bus.wreq.data;
                        strobe_q <= bus.wreq.strobe;
                        cnt_q    <= CNT_INIT;
                        ready_q  <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q <= MR_RESP;
                            resp_q  <= resp_d;
                        end else begin
                            state_q <= MR_WAIT;
                        end
                    end
                end
                MR_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == MR_CNT_W'(1)) begin
                        state_q <= MR_RESP;
                        resp_q  <= resp_d;
                    end
                end
                MR_RESP: begin
                    state_q <= MR_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= '0;
                end
                default: begin
                    state_q <= MR_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.resp      = resp_q;

endmodule
